vga_sync_gen: RTL and testbench

//  Timing source for the 640x480@60 Hz VGA path. Divides the system clock to the pixel rate and

---
 rtl/vga_timing_pkg.sv | 53 +++++
 rtl/pixel_tick_div.sv | 52 +++++
 rtl/vga_sync_gen.sv | 132 +++++++++++++
 tb/tb_vga_sync_gen.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Package: vga_timing_pkg
// Purpose: Shared 640x480@60 Hz timing constants for the VGA sync generator
//          and the downstream pixel/text generator, plus small coordinate
//          helpers used by the scan logic.
// Contents:
//   COORD_W            width of pixel_x / pixel_y (10 bits)
//   coord_t            coordinate type
//   *_DEF              default timing values (pixels / lines / clocks)
//   *_TOTAL_DEF        full line / frame lengths
//   *_SYNC_START/END   half-open sync pulse window [start, end)
//   in_window()        half-open range test on coordinates
//   wrap_inc()         increment with wrap to zero after a last value
package vga_timing_pkg;

  localparam int COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  localparam int CLK_DIV_DEF   = 4;

  localparam int H_DISPLAY_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int H_TOTAL_DEF   = H_DISPLAY_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;

  localparam int V_DISPLAY_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;
  localparam int V_TOTAL_DEF   = V_DISPLAY_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

  localparam int H_SYNC_START_DEF = H_DISPLAY_DEF + H_FRONT_DEF;
  localparam int H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF;
  localparam int V_SYNC_START_DEF = V_DISPLAY_DEF + V_FRONT_DEF;
  localparam int V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF;

  // True when lo <= v < hi, all at coordinate width.
  function automatic logic in_window(input coord_t v, input coord_t lo, input coord_t hi);
    return (v >= lo) && (v < hi);
  endfunction

  // Next coordinate along a scan axis: wraps to zero after 'last'.
  function automatic coord_t wrap_inc(input coord_t v, input coord_t last);
    coord_t r;
    if (v == last) begin
      r = {COORD_W{1'b0}};
    end else begin
      r = v + COORD_W'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/pixel_tick_div.sv
// Module: pixel_tick_div
// Purpose: Divides the system clock down to the pixel rate. A counter runs
//          0..CLK_DIV-1 while enabled and the strobe marks its last count.
// Ports:
//   clk     in   system clock
//   rst_n   in   asynchronous active-low reset
//   en      in   run enable; 0 freezes the counter and forces p_tick low
//   p_tick  out  one-clk pixel strobe, high while the counter sits at CLK_DIV-1
module pixel_tick_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic p_tick
);

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt_r;
  logic [DIV_W-1:0] div_cnt_next_s;

  // Next divider count: wraps at DIV_LAST, holds while disabled so a paused
  // pixel resumes with its remaining clocks intact.
  always_comb begin
    div_cnt_next_s = div_cnt_r;
    if (en) begin
      if (div_cnt_r == DIV_LAST) begin
        div_cnt_next_s = {DIV_W{1'b0}};
      end else begin
        div_cnt_next_s = div_cnt_r + DIV_W'(1);
      end
    end else begin
      div_cnt_next_s = div_cnt_r;
    end
  end

  // Divider count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_r <= {DIV_W{1'b0}};
    end else begin
      div_cnt_r <= div_cnt_next_s;
    end
  end

  // Decoded straight from the count register; en gating keeps the strobe low
  // while the scan is frozen.
  assign p_tick = en & (div_cnt_r == DIV_LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// Module: vga_sync_gen
// Purpose: VGA timing source. Divides clk to the pixel rate, runs the
//          horizontal/vertical scan counters and decodes blanking, syncs and
//          the frame-start marker for the pixel generator and connector.
// Ports:
//   clk          in   system clock (100 MHz)
//   rst_n        in   asynchronous active-low reset
//   en           in   run enable; 0 freezes all state and holds p_tick low
//   p_tick       out  pixel-rate strobe, one clk wide
//   pixel_x      out  current column 0..H_TOTAL-1
//   pixel_y      out  current row 0..V_TOTAL-1
//   video_on     out  high inside the visible area
//   hsync        out  horizontal sync, active low
//   vsync        out  vertical sync, active low
//   frame_start  out  one-clk pulse after the scan wraps to (0,0)
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV   = CLK_DIV_DEF,
  parameter int H_DISPLAY = H_DISPLAY_DEF,
  parameter int H_FRONT   = H_FRONT_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BACK    = H_BACK_DEF,
  parameter int V_DISPLAY = V_DISPLAY_DEF,
  parameter int V_FRONT   = V_FRONT_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BACK    = V_BACK_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  output logic               p_tick,
  output logic [COORD_W-1:0] pixel_x,
  output logic [COORD_W-1:0] pixel_y,
  output logic               video_on,
  output logic               hsync,
  output logic               vsync,
  output logic               frame_start
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  // All compare constants are pre-sized to the coordinate width.
  localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
  localparam coord_t H_VIS    = coord_t'(H_DISPLAY);
  localparam coord_t V_VIS    = coord_t'(V_DISPLAY);
  localparam coord_t HS_START = coord_t'(H_DISPLAY + H_FRONT);
  localparam coord_t HS_END   = coord_t'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam coord_t VS_START = coord_t'(V_DISPLAY + V_FRONT);
  localparam coord_t VS_END   = coord_t'(V_DISPLAY + V_FRONT + V_SYNC);

  logic   p_tick_s;
  logic   adv_s;
  logic   x_wrap_s;
  logic   y_wrap_s;
  logic   frame_wrap_s;
  coord_t x_next_s;
  coord_t y_next_s;

  coord_t pixel_x_r;
  coord_t pixel_y_r;
  logic   video_on_r;
  logic   hsync_r;
  logic   vsync_r;
  logic   frame_start_r;

  pixel_tick_div #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .p_tick (p_tick_s)
  );

  assign adv_s    = p_tick_s & en;
  assign x_wrap_s = (pixel_x_r == H_LAST);
  assign y_wrap_s = (pixel_y_r == V_LAST);

  // Next scan position. The row steps on the same edge the column wraps, and
  // the frame wraps only when both wrap together.
  always_comb begin
    x_next_s     = pixel_x_r;
    y_next_s     = pixel_y_r;
    frame_wrap_s = 1'b0;
    if (adv_s) begin
      x_next_s = wrap_inc(pixel_x_r, H_LAST);
      if (x_wrap_s) begin
        y_next_s     = wrap_inc(pixel_y_r, V_LAST);
        frame_wrap_s = y_wrap_s;
      end else begin
        y_next_s     = pixel_y_r;
        frame_wrap_s = 1'b0;
      end
    end else begin
      x_next_s     = pixel_x_r;
      y_next_s     = pixel_y_r;
      frame_wrap_s = 1'b0;
    end
  end

  // Scan registers. Flags are decoded from the next-state coordinates so
  // they change on the same edge as pixel_x/pixel_y (no pipeline lag).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_x_r     <= {COORD_W{1'b0}};
      pixel_y_r     <= {COORD_W{1'b0}};
      video_on_r    <= 1'b0;
      hsync_r       <= 1'b1;
      vsync_r       <= 1'b1;
      frame_start_r <= 1'b0;
    end else if (en) begin
      pixel_x_r     <= x_next_s;
      pixel_y_r     <= y_next_s;
      video_on_r    <= (x_next_s < H_VIS) && (y_next_s < V_VIS);
      hsync_r       <= ~in_window(x_next_s, HS_START, HS_END);
      vsync_r       <= ~in_window(y_next_s, VS_START, VS_END);
      frame_start_r <= frame_wrap_s;
    end
  end

  assign p_tick      = p_tick_s;
  assign pixel_x     = pixel_x_r;
  assign pixel_y     = pixel_y_r;
  assign video_on    = video_on_r;
  assign hsync       = hsync_r;
  assign vsync       = vsync_r;
  assign frame_start = frame_start_r;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Testbench: tb_vga_sync_gen
// Purpose: Directed, table-driven checks of vga_sync_gen. A default-timing
//          instance covers reset, first-line timing and the enable freeze; a
//          reduced-timing CLK_DIV=2 instance covers whole frames, vsync,
//          frame_start spacing and an asynchronous mid-frame reset.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default instance
  logic       rst_n, en;
  logic       p_tick, video_on, hsync, vsync, frame_start;
  logic [9:0] pixel_x, pixel_y;

  // Small instance: 24x15 total, CLK_DIV=2, sync x in [18,21), y in [10,12)
  logic       sm_rst_n, sm_en;
  logic       sm_p_tick, sm_video_on, sm_hsync, sm_vsync, sm_frame_start;
  logic [9:0] sm_pixel_x, sm_pixel_y;

  vga_sync_gen dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .p_tick      (p_tick),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .video_on    (video_on),
    .hsync       (hsync),
    .vsync       (vsync),
    .frame_start (frame_start)
  );

  vga_sync_gen #(
    .CLK_DIV(2), .H_DISPLAY(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_DISPLAY(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
  ) dut_sm (
    .clk         (clk),
    .rst_n       (sm_rst_n),
    .en          (sm_en),
    .p_tick      (sm_p_tick),
    .pixel_x     (sm_pixel_x),
    .pixel_y     (sm_pixel_y),
    .video_on    (sm_video_on),
    .hsync       (sm_hsync),
    .vsync       (sm_vsync),
    .frame_start (sm_frame_start)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int   edge_no;   // posedges since reset release
    logic tick;
    int   x;
    int   y;
    logic von;
    logic hs;
    logic vs;
    logic fs;
  } vec_t;

  vec_t vecs[15];

  task automatic check_main(input string tag, input logic t, input int x, input int y,
                            input logic v, input logic h, input logic vs_e, input logic f);
    check({tag, ".p_tick"},      {31'd0, p_tick},      {31'd0, t});
    check({tag, ".pixel_x"},     {22'd0, pixel_x},     x);
    check({tag, ".pixel_y"},     {22'd0, pixel_y},     y);
    check({tag, ".video_on"},    {31'd0, video_on},    {31'd0, v});
    check({tag, ".hsync"},       {31'd0, hsync},       {31'd0, h});
    check({tag, ".vsync"},       {31'd0, vsync},       {31'd0, vs_e});
    check({tag, ".frame_start"}, {31'd0, frame_start}, {31'd0, f});
  endtask

  task automatic check_sm(input string tag, input logic t, input int x, input int y,
                          input logic v, input logic h, input logic vs_e, input logic f);
    check({tag, ".p_tick"},      {31'd0, sm_p_tick},      {31'd0, t});
    check({tag, ".pixel_x"},     {22'd0, sm_pixel_x},     x);
    check({tag, ".pixel_y"},     {22'd0, sm_pixel_y},     y);
    check({tag, ".video_on"},    {31'd0, sm_video_on},    {31'd0, v});
    check({tag, ".hsync"},       {31'd0, sm_hsync},       {31'd0, h});
    check({tag, ".vsync"},       {31'd0, sm_vsync},       {31'd0, vs_e});
    check({tag, ".frame_start"}, {31'd0, sm_frame_start}, {31'd0, f});
  endtask

  initial begin
    int cur;
    int mis_x, mis_y, mis_t, mis_v, mis_h, mis_vs, mis_f;
    int n_fs, first_fs, gap_fs, last_fs, n_vs_low, n_hs_low, n_tick;

    // Cumulative edge count -> expected outputs, default 800x525, CLK_DIV=4.
    // Pixel x starts at edge 4*x; p_tick is high on the last clk of each pixel.
    vecs[0]  = '{0,    1'b0, 0,   0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[1]  = '{1,    1'b0, 0,   0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{3,    1'b1, 0,   0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{4,    1'b0, 1,   0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{7,    1'b1, 1,   0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{8,    1'b0, 2,   0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{2556, 1'b0, 639, 0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{2559, 1'b1, 639, 0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{2560, 1'b0, 640, 0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{2620, 1'b0, 655, 0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{2624, 1'b0, 656, 0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{3004, 1'b0, 751, 0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{3008, 1'b0, 752, 0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[13] = '{3196, 1'b0, 799, 0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[14] = '{3200, 1'b0, 0,   1, 1'b1, 1'b1, 1'b1, 1'b0};

    rst_n = 1'b0; en = 1'b1;
    sm_rst_n = 1'b0; sm_en = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    cur = 0;
    for (int i = 0; i < 15; i++) begin
      if (vecs[i].edge_no > cur) begin
        repeat (vecs[i].edge_no - cur) @(posedge clk);
        #2;
      end
      cur = vecs[i].edge_no;
      check_main($sformatf("vec%0d", i), vecs[i].tick, vecs[i].x, vecs[i].y,
                 vecs[i].von, vecs[i].hs, vecs[i].vs, vecs[i].fs);
    end

    // Freeze at x=100 with two divider clocks already spent on that pixel.
    repeat (402) @(posedge clk);
    #2;
    check_main("pre_freeze", 1'b0, 100, 1, 1'b1, 1'b1, 1'b1, 1'b0);
    en = 1'b0;
    #1 check("freeze_tick_low", {31'd0, p_tick}, 32'd0);
    repeat (10) @(posedge clk);
    #2 check_main("frozen", 1'b0, 100, 1, 1'b1, 1'b1, 1'b1, 1'b0);
    en = 1'b1;
    @(posedge clk); #2;
    check_main("resume1", 1'b1, 100, 1, 1'b1, 1'b1, 1'b1, 1'b0);
    @(posedge clk); #2;
    check_main("resume2", 1'b0, 101, 1, 1'b1, 1'b1, 1'b1, 1'b0);

    // Reduced-timing instance: two full frames against a reference scan model.
    #1 sm_rst_n = 1'b1;
    #1;
    check_sm("sm_reset", 1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b0);
    mis_x = 0; mis_y = 0; mis_t = 0; mis_v = 0; mis_h = 0; mis_vs = 0; mis_f = 0;
    n_fs = 0; first_fs = -1; gap_fs = -1; last_fs = -1;
    n_vs_low = 0; n_hs_low = 0; n_tick = 0;
    for (int e = 1; e <= 1500; e++) begin
      int lin, ex, ey;
      @(posedge clk); #2;
      lin = (e / 2) % 360;
      ex  = lin % 24;
      ey  = lin / 24;
      if (sm_pixel_x !== 10'(ex)) mis_x++;
      if (sm_pixel_y !== 10'(ey)) mis_y++;
      if (sm_p_tick !== ((e % 2) == 1)) mis_t++;
      if (sm_video_on !== ((ex < 16) && (ey < 8))) mis_v++;
      if (sm_hsync !== !((ex >= 18) && (ex < 21))) mis_h++;
      if (sm_vsync !== !((ey >= 10) && (ey < 12))) mis_vs++;
      if (sm_frame_start !== ((e % 720) == 0)) mis_f++;
      if (sm_p_tick === 1'b1) n_tick++;
      if (sm_hsync === 1'b0) n_hs_low++;
      if (sm_vsync === 1'b0) n_vs_low++;
      if (sm_frame_start === 1'b1) begin
        n_fs++;
        if (first_fs < 0) first_fs = e;
        else if (gap_fs < 0) gap_fs = e - last_fs;
        last_fs = e;
      end
    end
    check("sm_x_mismatches",   mis_x,  0);
    check("sm_y_mismatches",   mis_y,  0);
    check("sm_tick_mismatches", mis_t, 0);
    check("sm_von_mismatches", mis_v,  0);
    check("sm_hs_mismatches",  mis_h,  0);
    check("sm_vs_mismatches",  mis_vs, 0);
    check("sm_fs_mismatches",  mis_f,  0);
    check("sm_tick_count",     n_tick, 750);
    check("sm_hs_low_clks",    n_hs_low, 186);
    check("sm_vs_low_clks",    n_vs_low, 192);
    check("sm_fs_pulses",      n_fs, 2);
    check("sm_fs_first_edge",  first_fs, 720);
    check("sm_fs_gap",         gap_fs, 720);

    // Async reset mid-frame at (19,7), inside the hsync pulse, 3 ns wide.
    repeat (314) @(posedge clk);
    #2 check_sm("sm_pre_rst", 1'b0, 19, 7, 1'b0, 1'b0, 1'b1, 1'b0);
    #1 sm_rst_n = 1'b0;
    #1 check_sm("sm_in_rst", 1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b0);
    #2 sm_rst_n = 1'b1;
    @(posedge clk); #2;
    check_sm("sm_post_rst1", 1'b1, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0);
    @(posedge clk); #2;
    check_sm("sm_post_rst2", 1'b0, 1, 0, 1'b1, 1'b1, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
